// File: rtl/rvfi_pkg.sv
// rtl/rvfi_pkg.sv - shared types for the RVFI commit tracker
package rvfi_pkg;

  // Fields of one instruction retiring from the writeback stage
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        load_regfile;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } wb_commit_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } tracker_state_t;

  // RVFI requires rd fields to read as zero when no register is written
  // (no regfile write, or a write aimed at x0).
  function automatic wb_commit_t sanitize_commit(wb_commit_t f);
    wb_commit_t r;
    r = f;
    if (!f.load_regfile || (f.rd_addr == 5'd0)) begin
      r.rd_addr  = 5'd0;
      r.rd_wdata = 32'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 16,
  parameter int LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  // Clear wins over increment; increments stop once the limit is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIM)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rvfi_commit_tracker.sv
// rtl/rvfi_commit_tracker.sv - registers writeback retirements into RVFI commits with halt/continuity/stall monitors
module rvfi_commit_tracker
  import rvfi_pkg::*;
#(
  parameter int HALT_REPEAT = 2,
  parameter int IDLE_LIMIT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  wb_commit_t  wb_fields,
  output logic        commit,
  output logic [63:0] order,
  output wb_commit_t  fields,
  output logic        halt,
  output logic        pc_err,
  output logic [63:0] pc_err_order,
  output logic        stall
);

  localparam int              IDLE_W   = $clog2(IDLE_LIMIT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(IDLE_LIMIT);
  localparam logic [3:0]      HALT_CNT = 4'(HALT_REPEAT);

  tracker_state_t    state;
  logic              accept;
  logic              self_loop;
  logic [3:0]        loop_cnt;
  logic [3:0]        loop_inc;
  logic [63:0]       order_cnt;
  logic              first;
  logic [IDLE_W-1:0] idle_cnt;

  assign accept    = wb_valid && (state == RUN);
  assign self_loop = (wb_fields.pc_wdata == wb_fields.pc_rdata);
  assign loop_inc  = loop_cnt + 4'd1;

  // Commit pipeline: one-cycle registered copy of the retiring instruction.
  // order_cnt is the index the next commit will carry; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit    <= 1'b0;
      order     <= 64'd0;
      order_cnt <= 64'd0;
      fields    <= '0;
    end else begin
      commit <= accept;
      if (accept) begin
        order     <= order_cnt;
        order_cnt <= order_cnt + 64'd1;
        fields    <= sanitize_commit(wb_fields);
      end
    end
  end

  // Halt FSM: count consecutive self-loop commits, halt when the run completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      halt     <= 1'b0;
      loop_cnt <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            if (self_loop) begin
              loop_cnt <= loop_inc;
              if (loop_inc == HALT_CNT) begin
                state <= HALTED;
                halt  <= 1'b1;
              end
            end else begin
              loop_cnt <= 4'd0;
            end
          end
        end
        HALTED: begin
          halt <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // PC continuity: the previous commit's pc_wdata is still held in fields,
  // since sanitising never touches the PC fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first        <= 1'b1;
      pc_err       <= 1'b0;
      pc_err_order <= 64'd0;
    end else if (accept) begin
      first <= 1'b0;
      if (!first && (wb_fields.pc_rdata != fields.pc_wdata)) begin
        pc_err <= 1'b1;
        if (!pc_err) begin
          pc_err_order <= order_cnt;
        end
      end
    end
  end

  sat_counter #(
    .WIDTH (IDLE_W),
    .LIMIT (IDLE_LIMIT)
  ) u_idle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (1'b1),
    .count (idle_cnt)
  );

  assign stall = (idle_cnt == IDLE_LIM) && (state == RUN);

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// tb/tb_rvfi_commit_tracker.sv - self-checking bench for rvfi_commit_tracker
module tb_rvfi_commit_tracker;
  import rvfi_pkg::*;

  localparam int HR = 2;
  localparam int IL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  wb_commit_t  wb_fields;
  logic        commit;
  logic [63:0] order;
  wb_commit_t  fields;
  logic        halt;
  logic        pc_err;
  logic [63:0] pc_err_order;
  logic        stall;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        e_commit;
  logic [63:0] e_order;
  logic [63:0] m_next;
  logic        m_halted;
  logic        m_err;
  logic [63:0] m_err_order;
  logic        m_first;
  logic [31:0] m_last_pc;
  int          m_run;
  int          m_idle;
  wb_commit_t  m_fields;

  always #5 clk = ~clk;

  rvfi_commit_tracker #(
    .HALT_REPEAT (HR),
    .IDLE_LIMIT  (IL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_fields    (wb_fields),
    .commit       (commit),
    .order        (order),
    .fields       (fields),
    .halt         (halt),
    .pc_err       (pc_err),
    .pc_err_order (pc_err_order),
    .stall        (stall)
  );

  function automatic wb_commit_t mk(input logic [31:0] pc_r, input logic [31:0] pc_w);
    wb_commit_t f;
    f.inst         = $urandom;
    f.pc_rdata     = pc_r;
    f.pc_wdata     = pc_w;
    f.rs1_addr     = 5'($urandom);
    f.rs2_addr     = 5'($urandom);
    f.rs1_rdata    = $urandom;
    f.rs2_rdata    = $urandom;
    f.rd_addr      = 5'($urandom);
    f.rd_wdata     = $urandom;
    f.load_regfile = 1'($urandom);
    f.mem_addr     = $urandom;
    f.mem_rmask    = 4'($urandom);
    f.mem_wmask    = 4'($urandom);
    f.mem_rdata    = $urandom;
    f.mem_wdata    = $urandom;
    return f;
  endfunction

  function automatic wb_commit_t expect_sanitized(input wb_commit_t f);
    wb_commit_t r;
    r = f;
    if (f.load_regfile == 1'b0 || f.rd_addr == 5'd0) begin
      r.rd_addr  = 5'd0;
      r.rd_wdata = 32'd0;
    end
    return r;
  endfunction

  function automatic logic exp_stall();
    return (m_idle >= IL) && !m_halted;
  endfunction

  task automatic model_reset();
    e_commit    = 1'b0;
    e_order     = 64'd0;
    m_next      = 64'd0;
    m_halted    = 1'b0;
    m_err       = 1'b0;
    m_err_order = 64'd0;
    m_first     = 1'b1;
    m_last_pc   = 32'd0;
    m_run       = 0;
    m_idle      = 0;
    m_fields    = '0;
  endtask

  task automatic model_step(input logic v, input wb_commit_t f);
    if (v && !m_halted) begin
      e_commit = 1'b1;
      e_order  = m_next;
      m_next   = m_next + 64'd1;
      if (!m_first && f.pc_rdata != m_last_pc) begin
        if (!m_err) m_err_order = e_order;
        m_err = 1'b1;
      end
      m_first   = 1'b0;
      m_last_pc = f.pc_wdata;
      m_fields  = expect_sanitized(f);
      m_run     = (f.pc_wdata == f.pc_rdata) ? m_run + 1 : 0;
      if (m_run >= HR) m_halted = 1'b1;
      m_idle = 0;
    end else begin
      e_commit = 1'b0;
      if (m_idle < IL) m_idle = m_idle + 1;
    end
  endtask

  task automatic cycle(input logic v, input wb_commit_t f);
    wb_valid  = v;
    wb_fields = f;
    @(posedge clk);
    model_step(v, f);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    wb_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    wb_valid  = 1'b1;
    wb_fields = mk(32'h40, 32'h44);
    @(posedge clk);
    #1;
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL reset_commit got %0b want 0", commit); end
    checks++; if (order !== 64'd0) begin errors++; $display("FAIL reset_order got %0d want 0", order); end
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %0b want 0", halt); end
    checks++; if (pc_err !== 1'b0) begin errors++; $display("FAIL reset_pc_err got %0b want 0", pc_err); end
    checks++; if (pc_err_order !== 64'd0) begin errors++; $display("FAIL reset_pc_err_order got %0d want 0", pc_err_order); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
    checks++; if (fields !== wb_commit_t'('0)) begin errors++; $display("FAIL reset_fields got %h want 0", fields); end
    @(posedge clk);
    #1;
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL reset_ignores_valid got %0b want 0", commit); end
    rst      = 1'b0;
    wb_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    pcs[0] = 32'h60; pcs[1] = 32'h64; pcs[2] = 32'h68;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, mk(pcs[i], pcs[i] + 32'd4));
      checks++; if (commit !== 1'b1) begin errors++; $display("FAIL b2b_commit[%0d] got %0b want 1", i, commit); end
      checks++; if (order !== 64'(i)) begin errors++; $display("FAIL b2b_order[%0d] got %0d want %0d", i, order, i); end
      checks++; if (pc_err !== 1'b0) begin errors++; $display("FAIL b2b_pc_err[%0d] got %0b want 0", i, pc_err); end
      checks++; if (fields !== m_fields) begin errors++; $display("FAIL b2b_fields[%0d] got %h want %h", i, fields, m_fields); end
    end
    cycle(1'b0, mk(32'h0, 32'h0));
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL b2b_idle_commit got %0b want 0", commit); end
    checks++; if (order !== 64'd2) begin errors++; $display("FAIL b2b_idle_order got %0d want 2", order); end
  endtask

  task automatic test_halt();
    wb_commit_t frozen;
    do_reset();
    cycle(1'b1, mk(32'h80, 32'h80));
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_early got %0b want 0", halt); end
    cycle(1'b1, mk(32'h80, 32'h80));
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_rise got %0b want 1", halt); end
    checks++; if (commit !== 1'b1) begin errors++; $display("FAIL halt_commit got %0b want 1", commit); end
    checks++; if (order !== 64'd1) begin errors++; $display("FAIL halt_order got %0d want 1", order); end
    frozen = m_fields;
    cycle(1'b1, mk(32'h80, 32'h84));
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL halted_commit got %0b want 0", commit); end
    checks++; if (order !== 64'd1) begin errors++; $display("FAIL halted_order got %0d want 1", order); end
    checks++; if (fields !== frozen) begin errors++; $display("FAIL halted_fields got %h want %h", fields, frozen); end
    for (int i = 0; i < IL + 2; i++) cycle(1'b0, mk(32'h0, 32'h0));
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL halted_stall got %0b want 0", stall); end
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_sticky got %0b want 1", halt); end
  endtask

  task automatic test_no_halt();
    do_reset();
    cycle(1'b1, mk(32'h80, 32'h80));
    cycle(1'b1, mk(32'h80, 32'h84));
    cycle(1'b1, mk(32'h84, 32'h84));
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL nohalt_broken_run got %0b want 0", halt); end
    checks++; if (commit !== 1'b1) begin errors++; $display("FAIL nohalt_commit got %0b want 1", commit); end
    cycle(1'b1, mk(32'h84, 32'h84));
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL nohalt_then_halt got %0b want 1", halt); end
    checks++; if (order !== 64'd3) begin errors++; $display("FAIL nohalt_order got %0d want 3", order); end
  endtask

  task automatic test_pc_err();
    do_reset();
    cycle(1'b1, mk(32'h60, 32'h64));
    checks++; if (pc_err !== 1'b0) begin errors++; $display("FAIL pcerr_first got %0b want 0", pc_err); end
    cycle(1'b1, mk(32'h70, 32'h74));
    checks++; if (pc_err !== 1'b1) begin errors++; $display("FAIL pcerr_set got %0b want 1", pc_err); end
    checks++; if (pc_err_order !== 64'd1) begin errors++; $display("FAIL pcerr_order got %0d want 1", pc_err_order); end
    cycle(1'b1, mk(32'h74, 32'h78));
    checks++; if (pc_err !== 1'b1) begin errors++; $display("FAIL pcerr_sticky got %0b want 1", pc_err); end
    cycle(1'b1, mk(32'h90, 32'h94));
    checks++; if (pc_err_order !== 64'd1) begin errors++; $display("FAIL pcerr_order_kept got %0d want 1", pc_err_order); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b0, mk(32'h0, 32'h0));
      checks++; if (stall !== (i >= IL)) begin errors++; $display("FAIL stall_idle[%0d] got %0b want %0b", i, stall, (i >= IL)); end
    end
    cycle(1'b1, mk(32'h100, 32'h104));
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_clear got %0b want 0", stall); end
    checks++; if (commit !== 1'b1) begin errors++; $display("FAIL stall_clear_commit got %0b want 1", commit); end
    for (int i = 1; i < IL; i++) cycle(1'b0, mk(32'h0, 32'h0));
    cycle(1'b1, mk(32'h104, 32'h108));
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_commit_priority got %0b want 0", stall); end
    for (int i = 1; i <= IL; i++) cycle(1'b0, mk(32'h0, 32'h0));
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_again got %0b want 1", stall); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, mk(32'h200 + 32'(4 * i), 32'h204 + 32'(4 * i)));
    checks++; if (order !== 64'd4) begin errors++; $display("FAIL arst_pre_order got %0d want 4", order); end
    wb_valid = 1'b1;
    #3 rst = 1'b1;
    #1;
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL arst_commit got %0b want 0", commit); end
    checks++; if (order !== 64'd0) begin errors++; $display("FAIL arst_order got %0d want 0", order); end
    checks++; if (fields !== wb_commit_t'('0)) begin errors++; $display("FAIL arst_fields got %h want 0", fields); end
    #1 rst = 1'b0;
    model_reset();
    cycle(1'b1, mk(32'h900, 32'h904));
    checks++; if (order !== 64'd0) begin errors++; $display("FAIL arst_next_order got %0d want 0", order); end
    checks++; if (pc_err !== 1'b0) begin errors++; $display("FAIL arst_next_pc_err got %0b want 0", pc_err); end
    checks++; if (commit !== 1'b1) begin errors++; $display("FAIL arst_next_commit got %0b want 1", commit); end
  endtask

  task automatic test_random();
    logic [31:0] pc_r;
    logic [31:0] pc_w;
    logic        v;
    int          halted_cycles;
    halted_cycles = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v    = ($urandom_range(0, 9) < 7);
      pc_r = ($urandom_range(0, 11) == 0) ? {$urandom_range(0, 65535), 2'b00} : m_last_pc;
      pc_w = ($urandom_range(0, 5) == 0) ? pc_r : pc_r + 32'd4;
      cycle(v, mk(pc_r, pc_w));
      checks++; if (commit !== e_commit) begin errors++; $display("FAIL rnd_commit[%0d] got %0b want %0b", n, commit, e_commit); end
      checks++; if (order !== e_order) begin errors++; $display("FAIL rnd_order[%0d] got %0d want %0d", n, order, e_order); end
      checks++; if (halt !== m_halted) begin errors++; $display("FAIL rnd_halt[%0d] got %0b want %0b", n, halt, m_halted); end
      checks++; if (pc_err !== m_err) begin errors++; $display("FAIL rnd_pc_err[%0d] got %0b want %0b", n, pc_err, m_err); end
      checks++; if (pc_err_order !== m_err_order) begin errors++; $display("FAIL rnd_pc_err_order[%0d] got %0d want %0d", n, pc_err_order, m_err_order); end
      checks++; if (stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall[%0d] got %0b want %0b", n, stall, exp_stall()); end
      checks++; if (fields !== m_fields) begin errors++; $display("FAIL rnd_fields[%0d] got %h want %h", n, fields, m_fields); end
      if (m_halted) halted_cycles++;
      if (halted_cycles > 3) begin
        halted_cycles = 0;
        do_reset();
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    wb_valid  = 1'b0;
    wb_fields = '0;
    model_reset();
    test_reset();
    test_back_to_back();
    test_halt();
    test_no_halt();
    test_pc_err();
    test_stall();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
